// File: rtl/sad_frac_search_ctrl.sv
// Fractional-pel SAD search controller: streams ROWS+2 reference/original row
// beats into a three-row window, accumulates 25 candidate SADs from the
// combinational datapath, then scans for the minimum and presents it.
module sad_frac_search_ctrl #(
  parameter int ROWS  = 8,
  parameter int ACC_W = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [63:0]       in_ref_pix,
  input  logic [63:0]       in_org_pix,
  output logic [63:0]       cur_upper_pix,
  output logic [63:0]       cur_middle_pix,
  output logic [63:0]       cur_lower_pix,
  output logic [63:0]       org_pix,
  input  logic [59:0]       sad_uq,
  input  logic [59:0]       sad_uh,
  input  logic [59:0]       sad_middle,
  input  logic [59:0]       sad_lh,
  input  logic [59:0]       sad_lq,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [ACC_W-1:0]  res_sad,
  output logic [2:0]        res_vidx,
  output logic [2:0]        res_hidx
);

  localparam int BEAT_W = $clog2(ROWS + 2);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(ROWS + 1);

  typedef enum logic [2:0] {IDLE, FILL, DRAIN, SCAN, DONE} state_t;

  state_t             state, state_nxt;
  logic [BEAT_W-1:0]  beat_cnt;
  logic               acc_pulse;
  logic               xfer;
  logic [63:0]        org_hold;
  logic [59:0]        sad_bus [5];
  logic [ACC_W-1:0]   acc [25];
  logic [4:0]         scan_k;
  logic [2:0]         scan_v, scan_h;
  logic [ACC_W-1:0]   best;
  logic [2:0]         best_v, best_h;
  logic [ACC_W-1:0]   cur_best, cand, new_best;
  logic [2:0]         cur_v, cur_h, new_v, new_h;

  assign sad_bus[0] = sad_uq;
  assign sad_bus[1] = sad_uh;
  assign sad_bus[2] = sad_middle;
  assign sad_bus[3] = sad_lh;
  assign sad_bus[4] = sad_lq;

  assign xfer = in_valid && (state == FILL);

  // Next-state selection for the block sequence.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = FILL;
      FILL:    if (xfer && (beat_cnt == LAST_BEAT)) state_nxt = DRAIN;
      DRAIN:   state_nxt = SCAN;
      SCAN:    if (scan_k == 5'd24) state_nxt = DONE;
      DONE:    if (res_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State, beat counter, accumulate pulse and registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      beat_cnt  <= '0;
      acc_pulse <= 1'b0;
      busy      <= 1'b0;
      in_ready  <= 1'b0;
      res_valid <= 1'b0;
    end else begin
      state     <= state_nxt;
      busy      <= (state_nxt != IDLE);
      in_ready  <= (state_nxt == FILL);
      res_valid <= (state_nxt == DONE);
      // Beats 0 and 1 only prime the window; accumulation starts after beat 2.
      acc_pulse <= xfer && (beat_cnt >= BEAT_W'(2));
      if (state == IDLE && start) beat_cnt <= '0;
      else if (xfer)              beat_cnt <= beat_cnt + 1'b1;
    end
  end

  // Sliding row window and original-row alignment delay.
  always_ff @(posedge clk) begin
    if (rst) begin
      cur_upper_pix  <= '0;
      cur_middle_pix <= '0;
      cur_lower_pix  <= '0;
      org_hold       <= '0;
      org_pix        <= '0;
    end else if (xfer) begin
      cur_upper_pix  <= cur_middle_pix;
      cur_middle_pix <= cur_lower_pix;
      cur_lower_pix  <= in_ref_pix;
      org_hold       <= in_org_pix;
      org_pix        <= org_hold;
    end
  end

  // Candidate SAD accumulators, one per (vertical, horizontal) position.
  always_ff @(posedge clk) begin
    if (rst || (state == IDLE && start)) begin
      for (int k = 0; k < 25; k++) acc[k] <= '0;
    end else if (acc_pulse) begin
      for (int v = 0; v < 5; v++)
        for (int j = 0; j < 5; j++)
          acc[5*v+j] <= acc[5*v+j] + ACC_W'(sad_bus[v][12*j +: 12]);
    end
  end

  // Minimum-scan compare; the first step seeds from the center candidate.
  always_comb begin
    cur_best = (scan_k == 5'd0) ? acc[12] : best;
    cur_v    = (scan_k == 5'd0) ? 3'd2 : best_v;
    cur_h    = (scan_k == 5'd0) ? 3'd2 : best_h;
    cand     = acc[scan_k];
    new_best = cur_best;
    new_v    = cur_v;
    new_h    = cur_h;
    if (cand < cur_best) begin
      new_best = cand;
      new_v    = scan_v;
      new_h    = scan_h;
    end
  end

  // Scan index walk and result capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      scan_k   <= '0;
      scan_v   <= '0;
      scan_h   <= '0;
      best     <= '0;
      best_v   <= '0;
      best_h   <= '0;
      res_sad  <= '0;
      res_vidx <= '0;
      res_hidx <= '0;
    end else if (state == DRAIN) begin
      scan_k <= '0;
      scan_v <= '0;
      scan_h <= '0;
    end else if (state == SCAN) begin
      best   <= new_best;
      best_v <= new_v;
      best_h <= new_h;
      scan_k <= scan_k + 1'b1;
      if (scan_h == 3'd4) begin
        scan_h <= '0;
        scan_v <= scan_v + 1'b1;
      end else begin
        scan_h <= scan_h + 1'b1;
      end
      if (scan_k == 5'd24) begin
        res_sad  <= new_best;
        res_vidx <= new_v;
        res_hidx <= new_h;
      end
    end
  end

endmodule

// File: tb/tb_sad_frac_search_ctrl.sv
// Bench for sad_frac_search_ctrl: datapath stub, row-level reference model,
// expected results queued at block start and compared at the result handshake.
module tb_sad_frac_search_ctrl;

  localparam int ROWS  = 8;
  localparam int ACC_W = 15;

  logic             clk = 1'b0;
  logic             rst, start, in_valid, res_ready;
  logic             busy, in_ready, res_valid;
  logic [63:0]      in_ref_pix, in_org_pix;
  logic [63:0]      cur_upper_pix, cur_middle_pix, cur_lower_pix, org_pix;
  logic [59:0]      sad_uq, sad_uh, sad_middle, sad_lh, sad_lq;
  logic [59:0]      sad_w [5];
  logic [ACC_W-1:0] res_sad;
  logic [2:0]       res_vidx, res_hidx;

  int n_checks = 0;
  int n_fail   = 0;
  int mode     = 0;

  logic [63:0] refb [ROWS+2];
  logic [63:0] orgb [ROWS+2];

  typedef struct {
    logic [ACC_W-1:0] sad;
    logic [2:0]       v;
    logic [2:0]       h;
  } exp_t;
  exp_t sb [$];

  always #5 clk = ~clk;

  sad_frac_search_ctrl #(.ROWS(ROWS), .ACC_W(ACC_W)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_ref_pix(in_ref_pix), .in_org_pix(in_org_pix),
    .cur_upper_pix(cur_upper_pix), .cur_middle_pix(cur_middle_pix),
    .cur_lower_pix(cur_lower_pix), .org_pix(org_pix),
    .sad_uq(sad_uq), .sad_uh(sad_uh), .sad_middle(sad_middle),
    .sad_lh(sad_lh), .sad_lq(sad_lq),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_sad(res_sad), .res_vidx(res_vidx), .res_hidx(res_hidx)
  );

  // Datapath stand-in: field value per mode from the current window.
  function automatic logic [11:0] stub_f(input int m, input int v, input int j,
                                         input logic [63:0] up, input logic [63:0] mid,
                                         input logic [63:0] lo, input logic [63:0] org);
    case (m)
      0: return (v == 4 && j == 4) ? 12'd1 : 12'd100;
      1: return 12'd0;
      2: return ((v == 0 && j == 0) || (v == 1 && j == 1)) ? 12'd5 : 12'd9;
      default: return 12'(mid[8*j +: 8]) + 12'(lo[8*v +: 8])
                    + 12'(up[8*((j+v)%8) +: 8]) + 12'(org[7:0]);
    endcase
  endfunction

  always_comb begin
    for (int v = 0; v < 5; v++) begin
      sad_w[v] = '0;
      for (int j = 0; j < 5; j++)
        sad_w[v][12*j +: 12] = stub_f(mode, v, j, cur_upper_pix, cur_middle_pix,
                                      cur_lower_pix, org_pix);
    end
  end
  assign sad_uq     = sad_w[0];
  assign sad_uh     = sad_w[1];
  assign sad_middle = sad_w[2];
  assign sad_lh     = sad_w[3];
  assign sad_lq     = sad_w[4];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Row-level model: sum stub fields over the block rows, then pick the minimum.
  task automatic push_expected();
    int   a [25];
    exp_t e;
    int   best, bv, bh;
    for (int k = 0; k < 25; k++) a[k] = 0;
    for (int r = 0; r < ROWS; r++)
      for (int v = 0; v < 5; v++)
        for (int j = 0; j < 5; j++)
          a[5*v+j] += int'(stub_f(mode, v, j, refb[r], refb[r+1], refb[r+2], orgb[r+1]));
    best = a[12]; bv = 2; bh = 2;
    for (int k = 0; k < 25; k++)
      if (a[k] < best) begin best = a[k]; bv = k / 5; bh = k % 5; end
    e.sad = ACC_W'(best); e.v = 3'(bv); e.h = 3'(bh);
    sb.push_back(e);
  endtask

  task automatic new_rows(input bit zero);
    for (int b = 0; b < ROWS + 2; b++) begin
      refb[b] = zero ? 64'd0 : {$urandom, $urandom};
      orgb[b] = zero ? 64'd0 : {$urandom, $urandom};
    end
  endtask

  // Send beats first..last of the current row set, with optional random gaps.
  task automatic send_beats(input int first, input int last, input int gap_pct);
    int guard;
    for (int b = first; b <= last; b++) begin
      guard = 0;
      while (gap_pct > 0 && $urandom_range(99) < gap_pct && guard < 4) begin
        in_valid = 1'b0; tick(); guard++;
      end
      in_valid = 1'b1; in_ref_pix = refb[b]; in_org_pix = orgb[b];
      check("in_ready_fill", in_ready, 1);
      tick();
      in_valid = 1'b0; in_ref_pix = $urandom; in_org_pix = $urandom;
      check("cur_lower", cur_lower_pix, refb[b]);
      if (b >= 2) begin
        check("cur_middle", cur_middle_pix, refb[b-1]);
        check("org_pix_align", org_pix, orgb[b-1]);
      end
    end
  endtask

  task automatic run_block(input int gap_pct, input int hold_cycles);
    int   cnt;
    exp_t e;
    push_expected();
    start = 1'b1; tick(); start = 1'b0;
    check("busy_start", busy, 1);
    send_beats(0, ROWS + 1, gap_pct);
    // Beats offered during DRAIN/SCAN must not be consumed.
    in_valid = 1'b1;
    check("in_ready_drain", in_ready, 0);
    check("busy_drain", busy, 1);
    cnt = 1;
    while (!res_valid && cnt < 200) begin tick(); cnt++; end
    in_valid = 1'b0;
    check("latency", cnt, 27);
    if (sb.size() == 0) begin
      check("scoreboard_nonempty", 0, 1);
    end else begin
      e = sb.pop_front();
      check("res_sad", res_sad, e.sad);
      check("res_vidx", res_vidx, e.v);
      check("res_hidx", res_hidx, e.h);
      for (int i = 0; i < hold_cycles; i++) begin
        start = i[0];
        tick();
        check("hold_valid", res_valid, 1);
        check("hold_sad", res_sad, e.sad);
        check("hold_vidx", res_vidx, e.v);
        check("hold_hidx", res_hidx, e.h);
      end
    end
    res_ready = 1'b1; start = 1'b1; tick();
    res_ready = 1'b0; start = 1'b0;
    check("idle_busy", busy, 0);
    check("idle_valid", res_valid, 0);
    tick();
    check("idle_stays", busy, 0);
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_in_ready"}, in_ready, 0);
    check({tag, "_res_valid"}, res_valid, 0);
    check({tag, "_upper"}, cur_upper_pix, 0);
    check({tag, "_middle"}, cur_middle_pix, 0);
    check({tag, "_lower"}, cur_lower_pix, 0);
    check({tag, "_org"}, org_pix, 0);
    check({tag, "_sad"}, res_sad, 0);
    check({tag, "_vidx"}, res_vidx, 0);
    check({tag, "_hidx"}, res_hidx, 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; res_ready = 1'b0;
    in_ref_pix = '0; in_org_pix = '0;
    tick(); tick();
    rst = 1'b0;
    check_zero_outputs("reset");

    // Single low-cost lower-quarter candidate.
    mode = 0; new_rows(1'b0); run_block(0, 0);
    // Flat image: center wins the tie.
    mode = 1; new_rows(1'b1); run_block(0, 0);
    // Tie between two off-center candidates, lowest index wins; held result.
    mode = 2; new_rows(1'b0); run_block(0, 5);
    // Data-dependent sums, gap-free then the same rows with random gaps.
    mode = 3; new_rows(1'b0); run_block(0, 0);
    run_block(40, 0);

    // Reset in FILL after beat 4, then a fresh block.
    new_rows(1'b0);
    start = 1'b1; tick(); start = 1'b0;
    send_beats(0, 4, 0);
    rst = 1'b1; tick(); rst = 1'b0;
    check_zero_outputs("midrst");
    new_rows(1'b0); run_block(0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sad_frac_search_ctrl.md
# sad_frac_search_ctrl

Sequencer and arbiter-free controller for the combinational fractional-pel SAD datapath (`compute_sad`). It streams reference rows and original rows into a three-row sliding window that drives the datapath. Over a block of `ROWS` rows it accumulates the 25 candidate SADs (5 vertical × 5 horizontal sub-pel positions), then scans them for the minimum. It sits between the reference/original row fetch logic and the motion-vector refinement stage.

## Interface
- `ROWS`, default 8, block height in rows; must be at least 1.
- `ACC_W`, default 15, accumulator width; must be at least 12+clog2(`ROWS`); no saturation logic.
- `clk` input 1: the single clock.
- `rst` input 1: synchronous, active-high reset.
- `start` input 1: begins a block when in IDLE; ignored otherwise.
- `busy` output 1: high whenever state is not IDLE.
- `in_valid` input 1: row beat valid.
- `in_ready` output 1: high only in FILL.
- `in_ref_pix` input 64: reference row, 8 pixels × 8 bits.
- `in_org_pix` input 64: original row paired with the same reference row.
- `cur_upper_pix`, `cur_middle_pix`, `cur_lower_pix` output 64 each: window registers driven to the datapath.
- `org_pix` output 64: original row aligned with `cur_middle_pix`.
- `sad_uq`, `sad_uh`, `sad_middle`, `sad_lh`, `sad_lq` input 60 each: datapath results. Field j is bits [12j+11:12j], j = 0..4.
- `res_valid` output 1: result valid.
- `res_ready` input 1: result accept.
- `res_sad` output `ACC_W`: minimum accumulated SAD.
- `res_vidx` output 3: vertical index, 0=uq, 1=uh, 2=middle, 3=lh, 4=lq.
- `res_hidx` output 3: horizontal field index j.

## Operation
- States are IDLE, FILL, DRAIN, SCAN and DONE.
- **IDLE → FILL on `start`.**
  - All 25 accumulators are cleared.
  - The beat counter is set to 0.
- **FILL, beat transfer.**
  - A beat transfers when `in_valid` and `in_ready` are both high. Exactly `ROWS`+2 beats are taken.
  - Beat b carries reference row b−1, so beat 0 is the row above the block and beat `ROWS`+1 is the row below.
  - `in_org_pix` carries original row b−1. It is ignored on beats 0 and `ROWS`+1.
- **FILL, window update on each transfer.**
  - upper ← middle, middle ← lower, lower ← `in_ref_pix`.
  - org_hold ← `in_org_pix`, and `org_pix` ← org_hold.
  - After beat b, `cur_middle_pix` holds reference row b−2 and `org_pix` holds original row b−2.
- **FILL, accumulation.**
  - After a transfer of beat b ≥ 2, a one-cycle accumulate pulse fires in the next cycle.
  - acc[v][j] += the 12-bit field j of sad_v. Values are zero-extended.
  - Gaps in `in_valid` stall the window. No accumulate fires without a new transfer.
- **FILL → DRAIN** after beat `ROWS`+1 transfers. DRAIN lasts one cycle and performs the final accumulate.
- **SCAN, 25 cycles.**
  - best is preloaded with the center candidate (v=2, j=2).
  - Index k = 5v+j runs 0..24, one per cycle.
  - best is replaced only if acc[k] < best (strictly less). Ties therefore prefer the center, then the lowest k.
- **DONE.**
  - `res_valid` is held high, and `res_*` are held stable until `res_ready`.
  - On the `res_valid`&&`res_ready` cycle the state goes to IDLE.
- `start` is ignored outside IDLE. `start` in the same cycle as the DONE handshake is ignored.
- **Reset, at any time including mid-block.**
  - Next state is IDLE.
  - Accumulators, window registers, `org_pix`, `res_*` and the counters are all 0.
  - `busy`, `in_ready` and `res_valid` are 0.

## Timing
- All outputs are registered.
- The datapath is combinational from the window registers: its sums are sampled in the cycle after the window update.
- With back-to-back beats, one accumulate happens per cycle, overlapped with the next transfer.
- Let edge E be the edge that transfers beat `ROWS`+1.
  - Cycle 1 after E is DRAIN.
  - Cycles 2–26 after E are SCAN.
  - `res_valid` rises at the edge starting cycle 27 after E.
- Minimum block latency, from the `start` cycle to `res_valid`, is `ROWS`+2+27 cycles with no gaps (37 for `ROWS`=8).
- `in_ready` is 0 in DRAIN, SCAN and DONE. Beats presented then are not consumed.

## Test plan
- **Stub returning 100 on all fields, except `sad_lq` field 4 = 1 per row; `ROWS`=8, back-to-back beats.** Required: `res_sad`=8, `res_vidx`=4, `res_hidx`=4, and `res_valid` exactly 27 cycles after the last beat.
- **All fields 0 (flat image, org = ref).** Required: `res_sad`=0, `res_vidx`=2, `res_hidx`=2 (center wins the tie).
- **Stub with `sad_uq` field 0 = 5 and `sad_uh` field 1 = 5, all else 9.** Required: `res_sad`=40, `res_vidx`=0, `res_hidx`=0 (lowest k wins).
- **`in_valid` toggling 1-0-1 randomly.** Required: exactly 10 transfers, identical result to the gap-free run, and no accumulate on idle cycles. Check `org_pix` = original row b−2 after each beat.
- **`res_ready` held 0 for 5 cycles in DONE, with `start` pulsed.** Required: `res_*` stable, `start` ignored, IDLE after the handshake.
- **`rst` asserted in FILL after beat 4.** Required: next cycle IDLE, all outputs 0. A new block then produces a correct result unaffected by the partial sums.
